// File: rtl/io_input_port_if.sv
// -----------------------------------------------------------------------------
// io_input_port_if
// CPU data-bus bundle between the processor and the I/O input port.
//
// Signals:
//   addr      [31:0]  CPU data address; the I/O region is selected by addr[8]=1
//   writedata [31:0]  CPU store data
//   memwrite          CPU store strobe, qualified on the rising clk edge
//   iodata    [31:0]  read data returned by the port for I/O addresses
//
// Modports:
//   master  - CPU side (drives address, data and strobe, receives iodata)
//   slave   - peripheral side (receives address, data and strobe, drives iodata)
// -----------------------------------------------------------------------------
interface io_input_port_if;
  logic [31:0] addr;
  logic [31:0] writedata;
  logic        memwrite;
  logic [31:0] iodata;

  modport master (
    output addr,
    output writedata,
    output memwrite,
    input  iodata
  );

  modport slave (
    input  addr,
    input  writedata,
    input  memwrite,
    output iodata
  );
endinterface

// File: rtl/io_input_port.sv
// -----------------------------------------------------------------------------
// io_input_port
// Memory-mapped input peripheral for 10 slide switches and 3 push buttons.
// Every input is brought into the clock domain by a 2-flop synchronizer and,
// optionally, debounced. Debounced button rising edges ("press events") set
// sticky write-1-to-clear flags and advance an 8-bit wrapping press counter.
//
// Optional feature macro: IO_INPUT_DEBOUNCE_EN
//   defined   - each bit must differ from its debounced value for
//               DEBOUNCE_CYCLES consecutive edges before it is accepted
//   undefined - debounced value is the synchronized value (2-edge latency),
//               DEBOUNCE_CYCLES is ignored
//
// Parameters:
//   DEBOUNCE_CYCLES  stability requirement in clk edges (1..255), default 4
//
// Ports:
//   clk     in   system clock, rising edge active
//   reset   in   asynchronous, active-high reset
//   sw      in   [9:0] slide switches, asynchronous, active-high
//   key_n   in   [2:0] push buttons KEY[3:1], asynchronous, active-low
//   bus     slave modport of io_input_port_if (addr, writedata, memwrite, iodata)
//
// Register map (addr[8]=1, read priority addr[4] > addr[5] > addr[6] > addr[7]):
//   0x110  R   {22'b0, debounced switches}
//   0x120  R   {29'b0, debounced keys}
//   0x140  R/W {29'b0, press flags}; a store clears flags where writedata[2:0]=1
//   0x180  R/W {24'b0, press counter}; a store loads this cycle's press count
// -----------------------------------------------------------------------------
module io_input_port #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] sw,
  input  logic [2:0] key_n,
  io_input_port_if.slave bus
);

  localparam int NUM_INPUTS = 13;

  // Bits 9:0 are the switches, bits 12:10 the keys, already made active-high.
  logic [NUM_INPUTS-1:0] raw_in;
  logic [NUM_INPUTS-1:0] sync_1;
  logic [NUM_INPUTS-1:0] sync_2;
  logic [NUM_INPUTS-1:0] debounced;

  logic [2:0] key_debounced;
  logic [2:0] key_prev;
  logic [2:0] press;
  logic [1:0] press_count;

  logic       store_flags;
  logic       store_count;
  logic [2:0] flags;
  logic [7:0] press_cnt;

  assign raw_in = {~key_n, sw};

  // Two-stage synchronizer; sync_2 is the first value safe to use in logic.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_1 <= '0;
      sync_2 <= '0;
    end else begin
      sync_1 <= raw_in;
      sync_2 <= sync_1;
    end
  end

`ifdef IO_INPUT_DEBOUNCE_EN
  localparam logic [7:0] STABLE_LIMIT = 8'(DEBOUNCE_CYCLES);

  logic [7:0] stable_cnt [NUM_INPUTS];

  // Each bit counts consecutive edges on which the synchronized value differs
  // from the accepted value. Any agreement restarts the count, so a glitch
  // shorter than the limit never reaches the debounced register. On the edge
  // where the count would hit the limit the new value is accepted and the
  // count restarts together with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      debounced <= '0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
        stable_cnt[i] <= 8'd0;
      end
    end else begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
        if (sync_2[i] == debounced[i]) begin
          stable_cnt[i] <= 8'd0;
        end else if (stable_cnt[i] + 8'd1 == STABLE_LIMIT) begin
          debounced[i]  <= sync_2[i];
          stable_cnt[i] <= 8'd0;
        end else begin
          stable_cnt[i] <= stable_cnt[i] + 8'd1;
        end
      end
    end
  end
`else
  // Without debouncing the parameter has no effect on the hardware.
  localparam int UNUSED_DEBOUNCE_CYCLES = DEBOUNCE_CYCLES;

  assign debounced = sync_2;
`endif

  assign key_debounced = debounced[12:10];

  // The delayed copy of the keys turns a debounced 0->1 into a single-cycle
  // press event. Because it resets to 0, a key held through reset release
  // yields exactly one press once it is accepted again.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_prev <= 3'b000;
    end else begin
      key_prev <= key_debounced;
    end
  end

  assign press       = key_debounced & ~key_prev;
  assign press_count = {1'b0, press[0]} + {1'b0, press[1]} + {1'b0, press[2]};

  // Store decode uses single address bits only; 0x110 and 0x120 have no
  // writable state so stores there fall through harmlessly.
  assign store_flags = bus.memwrite & bus.addr[8] & bus.addr[6];
  assign store_count = bus.memwrite & bus.addr[8] & bus.addr[7];

  // Sticky flags: the clear mask is applied first and the press events are
  // ORed in afterwards, so a press in the same cycle as a clear wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags <= 3'b000;
    end else if (store_flags) begin
      flags <= (flags & ~bus.writedata[2:0]) | press;
    end else begin
      flags <= flags | press;
    end
  end

  // Press counter wraps naturally at 8 bits. A store does not discard presses
  // that happen in the same cycle; it loads their count instead of zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      press_cnt <= 8'd0;
    end else if (store_count) begin
      press_cnt <= {6'd0, press_count};
    end else begin
      press_cnt <= press_cnt + {6'd0, press_count};
    end
  end

  // Read mux: purely combinational from registered state and the address.
  always_comb begin
    bus.iodata = 32'd0;
    if (bus.addr[8]) begin
      if (bus.addr[4]) begin
        bus.iodata = {22'd0, debounced[9:0]};
      end else if (bus.addr[5]) begin
        bus.iodata = {29'd0, key_debounced};
      end else if (bus.addr[6]) begin
        bus.iodata = {29'd0, flags};
      end else if (bus.addr[7]) begin
        bus.iodata = {24'd0, press_cnt};
      end
    end
  end

  // Address and data bits that play no part in decoding or storage.
  logic unused_bus_bits;
  assign unused_bus_bits = ^{bus.addr[31:9], bus.addr[3:0], bus.writedata[31:3]};

endmodule

// File: doc/io_input_port.md
IO_INPUT_PORT -- requirements
Module: io_input_port

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4, meaning consecutive clk edges an input must differ before being accepted (range 1..255).
REQ-002 SHALL have port clk  input  1  single system clock, rising-edge active.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port addr  input  32  CPU data address; I/O region selected by addr[8]=1.
REQ-005 SHALL have port writedata  input  32  CPU store data.
REQ-006 SHALL have port memwrite  input  1  CPU store strobe, qualified on the rising clk edge.
REQ-007 SHALL have port sw  input  10  slide switches, asynchronous, active-high.
REQ-008 SHALL have port key_n  input  3  push buttons KEY[3:1], asynchronous, active-low (pressed = 0).
REQ-009 SHALL have port iodata  output  32  read data for I/O addresses, combinational from registered state.

Function
REQ-010 SHALL pass sw and inverted key_n through a 2-flop synchronizer per bit; the second flop is the synchronized value.
REQ-011 SHALL keep a debounced register per bit (10 switch, 3 key) and a per-bit 8-bit stability counter.
REQ-012 Per bit: sync == debounced -> counter cleared to 0; sync != debounced -> counter increments; when it reaches DEBOUNCE_CYCLES the debounced bit takes the sync value and the counter clears on that same edge.
REQ-013 Input change before the synchronizer's first sampling edge SHALL be visible on the debounced bit exactly 2+DEBOUNCE_CYCLES edges later; a glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL never change the debounced bit.
REQ-014 SHALL hold a registered copy of the debounced keys; press event = debounced key 1 while the copy is 0.
REQ-015 On a press event, the corresponding bit of the 3-bit sticky flag register SHALL be set on the next edge.
REQ-016 Store to 0x0000_0140 (memwrite & addr[8] & addr[6]) SHALL clear each flag bit whose writedata[2:0] bit is 1 (write-1-to-clear); a simultaneous press event on the same bit SHALL win (flag stays 1).
REQ-017 SHALL keep an 8-bit press counter incremented by the number of press events (0..3) in the cycle, wrapping modulo 256 (255+1 -> 0).
REQ-018 Store to 0x0000_0180 (memwrite & addr[8] & addr[7]) SHALL load the press counter with the press-event count of that cycle (0 if none).
REQ-019 Read map (addr[8]=1), priority addr[4] > addr[5] > addr[6] > addr[7]: 0x110 -> {22'b0, debounced sw}; 0x120 -> {29'b0, debounced keys}; 0x140 -> {29'b0, flags}; 0x180 -> {24'b0, press counter}.
REQ-020 iodata SHALL be 0 when addr[8]=0 or no select bit of addr[7:4] is set.
REQ-021 Stores with addr[8]=0, or to 0x110/0x120, SHALL have no effect on any state.

Reset
REQ-022 Assertion of reset SHALL immediately clear synchronizers, debounced registers, key copy, stability counters, flags and press counter to 0, regardless of clk.
REQ-023 Reset asserted mid-debounce SHALL abandon the pending transition; after release a held input is re-accepted after the full 2+DEBOUNCE_CYCLES edges.
REQ-024 A key held during reset release SHALL produce exactly one press event once debounced.

Configuration
REQ-025 Macro IO_INPUT_DEBOUNCE_EN defined: debounce per REQ-011..013.
REQ-026 Macro IO_INPUT_DEBOUNCE_EN undefined: stability counters SHALL be absent, debounced bit equals synchronized bit (latency 2 edges), DEBOUNCE_CYCLES ignored; all other behaviour unchanged.

Verification
REQ-027 Debounce on, DEBOUNCE_CYCLES=4: sw=10'h2A5 from reset -> read 0x110 returns 0x000002A5 on 6th edge, 0 before.
REQ-028 key_n[0] low for 3 synchronized cycles then high -> read 0x120 and 0x140 stay 0, press counter stays 0.
REQ-029 key_n[1] held low 10 cycles -> 0x120 = 0x2, 0x140 = 0x2, 0x180 = 1; store 0x2 to 0x140 -> 0x140 = 0 next cycle, 0x120 still 0x2.
REQ-030 Press event on key 2 in the same cycle as store 0x7 to 0x140 -> flag bit 2 remains 1, bits 1:0 cleared.
REQ-031 256 debounced presses of key 0 from reset -> 0x180 reads 0 (wrap); store to 0x180 -> reads 0; reset mid-debounce of sw[9] -> 0x110 reads 0 until 6 edges after release.
REQ-032 Debounce compiled out: sw change -> 0x110 updated on 2nd edge; 1-cycle key glitch -> one press event.
